mem_access_stage: RTL and testbench

- Memory stage; consumes the 14-bit execute-stage control word plus the ALU result and forwarded rs2 value.
- Registers each instruction and performs the load/store on the data-memory bus using a req/gnt then rvalid handshake.
- Aligns, masks and sign-extends load data and emits a single-cycle writeback beat.
- Back-pressures the execute stage while a memory transaction is outstanding.

---
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers one instruction, runs its load/store on the
// req/gnt + rvalid data bus, and emits a single-cycle writeback beat.
module mem_access_stage #(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [13:0] control_word_ex,
    input  logic [31:0] ALU_result,
    input  logic [31:0] regfileb_ex,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_misalign,
    output logic        wb_bus_err
);

    localparam int unsigned CNT_W = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             r_store;
    logic             r_rf_wb;
    logic [4:0]       r_rd;
    logic [2:0]       r_f3;
    logic [1:0]       r_addr_lo;

    // Control word fields; branch_taken and pc_src belong to earlier stages.
    logic       in_rf_wb;
    logic       in_mem_we;
    logic [1:0] in_wb_src;
    logic [4:0] in_rd;
    logic [2:0] in_f3;
    logic       unused_ctrl;

    assign in_rf_wb    = control_word_ex[12];
    assign in_mem_we   = control_word_ex[11];
    assign in_wb_src   = control_word_ex[10:9];
    assign in_rd       = control_word_ex[7:3];
    assign in_f3       = control_word_ex[2:0];
    assign unused_ctrl = control_word_ex[13] ^ control_word_ex[8];

    logic        is_load_c;
    logic        is_mem_c;
    logic        misalign_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        cnt_hit_c;

    assign is_load_c = !in_mem_we && (in_wb_src == 2'b01);
    assign is_mem_c  = in_mem_we || is_load_c;
    assign cnt_hit_c = (cnt == CNT_W'(DMEM_TIMEOUT - 1));

    // Alignment check and store lane steering from the incoming instruction.
    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = regfileb_ex;
        case (in_f3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ALU_result[1:0];
                wdata_c = {4{regfileb_ex[7:0]}};
            end
            2'b01: begin
                misalign_c = ALU_result[0];
                be_c       = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{regfileb_ex[15:0]}};
            end
            2'b10:   misalign_c = |ALU_result[1:0];
            default: misalign_c = 1'b1;
        endcase
        if (!in_mem_we) be_c = 4'b1111;
    end

    logic [7:0]  lane_b_c;
    logic [15:0] lane_h_c;
    logic        sext_c;
    logic [31:0] load_data_c;

    // Load lane select and sign/zero extension.
    always_comb begin
        case (r_addr_lo)
            2'd0:    lane_b_c = dmem_rdata[7:0];
            2'd1:    lane_b_c = dmem_rdata[15:8];
            2'd2:    lane_b_c = dmem_rdata[23:16];
            default: lane_b_c = dmem_rdata[31:24];
        endcase
        lane_h_c = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        sext_c   = ~r_f3[2];
        case (r_f3[1:0])
            2'b00:   load_data_c = {{24{sext_c & lane_b_c[7]}}, lane_b_c};
            2'b01:   load_data_c = {{16{sext_c & lane_h_c[15]}}, lane_h_c};
            default: load_data_c = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_store     <= 1'b0;
            r_rf_wb     <= 1'b0;
            r_rd        <= '0;
            r_f3        <= '0;
            r_addr_lo   <= '0;
            ex_ready    <= 1'b1;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            wb_valid    <= 1'b0;
            wb_rf_we    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
            wb_bus_err  <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_rf_we    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
            wb_bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && ex_ready) begin
                        r_store   <= in_mem_we;
                        r_rf_wb   <= in_rf_wb;
                        r_rd      <= in_rd;
                        r_f3      <= in_f3;
                        r_addr_lo <= ALU_result[1:0];
                        if (!is_mem_c) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= in_rd;
                            wb_data  <= ALU_result;
                            wb_rf_we <= in_rf_wb && (in_rd != 5'd0);
                        end else if (misalign_c) begin
                            wb_valid    <= 1'b1;
                            wb_rd       <= in_rd;
                            wb_misalign <= 1'b1;
                        end else begin
                            state      <= REQ;
                            ex_ready   <= 1'b0;
                            cnt        <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= in_mem_we;
                            dmem_addr  <= {ALU_result[31:2], 2'b00};
                            dmem_be    <= be_c;
                            dmem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    // A grant in the final timeout cycle still wins.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt      <= '0;
                        if (r_store) begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_rd    <= r_rd;
                        end else begin
                            state <= WAIT_R;
                        end
                    end else if (cnt_hit_c) begin
                        dmem_req   <= 1'b0;
                        state      <= RESP;
                        wb_valid   <= 1'b1;
                        wb_rd      <= r_rd;
                        wb_bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        state    <= RESP;
                        wb_valid <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_data  <= load_data_c;
                        wb_rf_we <= r_rf_wb && (r_rd != 5'd0);
                    end else if (cnt_hit_c) begin
                        state      <= RESP;
                        wb_valid   <= 1'b1;
                        wb_rd      <= r_rd;
                        wb_bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table with a small bus responder,
// plus hand sequences for late grant after timeout and reset mid-transaction.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [13:0] control_word_ex;
    logic [31:0] ALU_result;
    logic [31:0] regfileb_ex;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_misalign;
    logic        wb_bus_err;

    mem_access_stage #(.DMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .control_word_ex(control_word_ex), .ALU_result(ALU_result), .regfileb_ex(regfileb_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [13:0] cw;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        early;
        int          e_nreq;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        int          e_lat;
        logic [31:0] e_data;
        logic        e_rfwe;
        logic [4:0]  e_rd;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [13:0] mkcw(input logic bt, input logic rf, input logic we,
                                         input logic [1:0] src, input logic pcs,
                                         input logic [4:0] rd, input logic [2:0] f3);
        return {bt, rf, we, src, pcs, rd, f3};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   nreq;
        int   gnt_cyc;
        logic bad_bus;
        logic busy_ready;
        logic [31:0] g_data;
        logic g_rfwe, g_mis, g_err;
        logic [4:0] g_rd;
        lat = 0; nreq = 0; gnt_cyc = -1; bad_bus = 1'b0; busy_ready = 1'b0;
        g_data = '0; g_rfwe = 1'b0; g_mis = 1'b0; g_err = 1'b0; g_rd = '0;
        @(negedge clk);
        chk($sformatf("v%0d ready_at_issue", idx), 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; control_word_ex = v.cw; ALU_result = v.alu; regfileb_ex = v.rs2;
        @(negedge clk);
        ex_valid = 1'b0; control_word_ex = ~v.cw; ALU_result = ~v.alu; regfileb_ex = ~v.rs2;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
            if (v.e_nreq > 0 && ex_ready) busy_ready = 1'b1;
            if (wb_valid) begin
                lat = c; g_data = wb_data; g_rfwe = wb_rf_we; g_rd = wb_rd;
                g_mis = wb_misalign; g_err = wb_bus_err;
            end
            if (dmem_req) begin
                nreq++;
                if (dmem_addr !== v.e_addr || dmem_be !== v.e_be || dmem_we !== v.e_we ||
                    (v.e_we && dmem_wdata !== v.e_wdata)) bad_bus = 1'b1;
                if (nreq == v.gnt_dly + 1) begin
                    dmem_gnt = 1'b1; gnt_cyc = c;
                    if (v.early) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; end
                end
            end
            if (gnt_cyc > 0 && v.rv_dly > 0 && c == gnt_cyc + v.rv_dly) begin
                dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            end
            if (lat == 0) @(negedge clk);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk($sformatf("v%0d wb_latency", idx), 32'(lat), 32'(v.e_lat));
        chk($sformatf("v%0d wb_data", idx), g_data, v.e_data);
        chk($sformatf("v%0d wb_rf_we", idx), 32'(g_rfwe), 32'(v.e_rfwe));
        chk($sformatf("v%0d wb_rd", idx), 32'(g_rd), 32'(v.e_rd));
        chk($sformatf("v%0d wb_misalign", idx), 32'(g_mis), 32'(v.e_mis));
        chk($sformatf("v%0d wb_bus_err", idx), 32'(g_err), 32'(v.e_err));
        chk($sformatf("v%0d req_cycles", idx), 32'(nreq), 32'(v.e_nreq));
        if (v.e_nreq > 0) begin
            chk($sformatf("v%0d bus_fields_bad", idx), 32'(bad_bus), 32'd0);
            chk($sformatf("v%0d ready_while_busy", idx), 32'(busy_ready), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d wb_pulse_end", idx), 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; control_word_ex = '0; ALU_result = '0; regfileb_ex = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //                cw                                         alu           rs2           rdata         g    rv early nreq addr         be       we    wdata         lat data          rfwe  rd     mis   err
        tbl[0]  = '{mkcw(1'b0,1'b1,1'b0,2'b00,1'b0,5'd5, 3'b000), 32'h00001234, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h00001234, 1'b1, 5'd5,  1'b0, 1'b0};
        tbl[1]  = '{mkcw(1'b1,1'b1,1'b0,2'b00,1'b1,5'd0, 3'b000), 32'hCAFE0000, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'hCAFE0000, 1'b0, 5'd0,  1'b0, 1'b0};
        tbl[2]  = '{mkcw(1'b0,1'b0,1'b0,2'b10,1'b0,5'd7, 3'b000), 32'h00000055, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h00000055, 1'b0, 5'd7,  1'b0, 1'b0};
        tbl[3]  = '{mkcw(1'b0,1'b0,1'b1,2'b00,1'b0,5'd0, 3'b000), 32'h00001003, 32'hAABBCCDD, 32'h0,        3,   0, 1'b0, 4, 32'h00001000, 4'b1000, 1'b1, 32'hDDDDDDDD, 5, 32'h0,        1'b0, 5'd0,  1'b0, 1'b0};
        tbl[4]  = '{mkcw(1'b0,1'b0,1'b1,2'b00,1'b0,5'd0, 3'b001), 32'h00001006, 32'h11223344, 32'h0,        0,   0, 1'b0, 1, 32'h00001004, 4'b1100, 1'b1, 32'h33443344, 2, 32'h0,        1'b0, 5'd0,  1'b0, 1'b0};
        tbl[5]  = '{mkcw(1'b0,1'b0,1'b1,2'b00,1'b0,5'd0, 3'b010), 32'h00001008, 32'h89ABCDEF, 32'h0,        1,   0, 1'b0, 2, 32'h00001008, 4'b1111, 1'b1, 32'h89ABCDEF, 3, 32'h0,        1'b0, 5'd0,  1'b0, 1'b0};
        tbl[6]  = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd10,3'b000), 32'h00002001, 32'h0,        32'h00008000, 0,   1, 1'b0, 1, 32'h00002000, 4'b1111, 1'b0, 32'h0,        3, 32'hFFFFFF80, 1'b1, 5'd10, 1'b0, 1'b0};
        tbl[7]  = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd10,3'b100), 32'h00002001, 32'h0,        32'h00008000, 0,   1, 1'b0, 1, 32'h00002000, 4'b1111, 1'b0, 32'h0,        3, 32'h00000080, 1'b1, 5'd10, 1'b0, 1'b0};
        tbl[8]  = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd3, 3'b010), 32'h00002004, 32'h0,        32'h12345678, 0,   1, 1'b1, 1, 32'h00002004, 4'b1111, 1'b0, 32'h0,        3, 32'h12345678, 1'b1, 5'd3,  1'b0, 1'b0};
        tbl[9]  = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd4, 3'b001), 32'h00002002, 32'h0,        32'h80010000, 2,   2, 1'b0, 3, 32'h00002000, 4'b1111, 1'b0, 32'h0,        6, 32'hFFFF8001, 1'b1, 5'd4,  1'b0, 1'b0};
        tbl[10] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd11,3'b101), 32'h00002000, 32'h0,        32'h1234F00D, 0,   3, 1'b0, 1, 32'h00002000, 4'b1111, 1'b0, 32'h0,        5, 32'h0000F00D, 1'b1, 5'd11, 1'b0, 1'b0};
        tbl[11] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd6, 3'b010), 32'h00002002, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h0,        1'b0, 5'd6,  1'b1, 1'b0};
        tbl[12] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd7, 3'b001), 32'h00002001, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h0,        1'b0, 5'd7,  1'b1, 1'b0};
        tbl[13] = '{mkcw(1'b0,1'b0,1'b1,2'b00,1'b0,5'd0, 3'b010), 32'h00001001, 32'h5A5A5A5A, 32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h0,        1'b0, 5'd0,  1'b1, 1'b0};
        tbl[14] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd12,3'b011), 32'h00002000, 32'h0,        32'h0,        0,   0, 1'b0, 0, 32'h0,       4'b0000, 1'b0, 32'h0,        1, 32'h0,        1'b0, 5'd12, 1'b1, 1'b0};
        tbl[15] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd0, 3'b010), 32'h00002008, 32'h0,        32'hFFFFFFFF, 0,   1, 1'b0, 1, 32'h00002008, 4'b1111, 1'b0, 32'h0,        3, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 1'b0};
        tbl[16] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd13,3'b000), 32'h00002003, 32'h0,        32'h7F000000, 0,   1, 1'b0, 1, 32'h00002000, 4'b1111, 1'b0, 32'h0,        3, 32'h0000007F, 1'b1, 5'd13, 1'b0, 1'b0};
        tbl[17] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd14,3'b010), 32'h00003004, 32'h0,        32'h0,        0,   0, 1'b0, 1, 32'h00003004, 4'b1111, 1'b0, 32'h0,        6, 32'h0,        1'b0, 5'd14, 1'b0, 1'b1};
        tbl[18] = '{mkcw(1'b0,1'b1,1'b0,2'b01,1'b0,5'd8, 3'b010), 32'h00003000, 32'h0,        32'h0,        100, 0, 1'b0, 4, 32'h00003000, 4'b1111, 1'b0, 32'h0,        5, 32'h0,        1'b0, 5'd8,  1'b0, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst ex_ready", 32'(ex_ready), 32'd1);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_rf_we", 32'(wb_rf_we), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst wb_misalign", 32'(wb_misalign), 32'd0);
        chk("rst wb_bus_err", 32'(wb_bus_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

        // Grant and rvalid arriving after the timeout abort are ignored
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late%0d wb_valid", k), 32'(wb_valid), 32'd0);
            chk($sformatf("late%0d dmem_req", k), 32'(dmem_req), 32'd0);
            chk($sformatf("late%0d ex_ready", k), 32'(ex_ready), 32'd1);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset while waiting for read data drops the instruction
        @(negedge clk);
        ex_valid = 1'b1; control_word_ex = mkcw(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 3'b010);
        ALU_result = 32'h00004000; regfileb_ex = '0;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstmid req_issued", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rstmid in_wait_ready", 32'(ex_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid ex_ready", 32'(ex_ready), 32'd1);
        chk("rstmid dmem_req", 32'(dmem_req), 32'd0);
        chk("rstmid wb_valid", 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEBABE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            chk($sformatf("rstmid%0d no_wb", k), 32'(wb_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
